xif_copro_ctrl: RTL and testbench
=================================

# xif_copro_ctrl

Coprocessor-side eXtension-interface controller for the srv32 offload path. It sits directly downstream of the core's XIF issue, register, commit and result channels. It decodes offloaded custom-0 instructions and tracks up to DEPTH accepted instructions in an in-order queue. It captures their source operands, resolves commit or kill, executes a small integer ALU op, and returns results in issue order. The memory channels are not used by this block.

## Interface
- X_ID_WIDTH, 4, width of the instruction id.
- X_RFR_WIDTH, 32, operand width; also the result data width.
- DEPTH, 4, queue entries; must be a power of 2, at least 2.
- clk  in  1  clock, rising edge.
- resetb  in  1  asynchronous, active-low reset.
- issue_valid / issue_ready  in / out  1  issue handshake.
- issue_instr  in  32  offloaded instruction.
- issue_id  in  X_ID_WIDTH  instruction id.
- issue_accept, issue_writeback, issue_loadstore, issue_dualwrite, issue_exc  out  1 each  issue response.
- issue_dualread  out  3  issue response.
- register_valid / register_ready  in / out  1  register handshake.
- register_id  in  X_ID_WIDTH  id of the operand transfer.
- register_rs  in  2*X_RFR_WIDTH  operands; rs1 in the low half.
- register_rs_valid  in  2  per-operand valid flags.
- commit_valid  in  1  commit strobe.
- commit_id  in  X_ID_WIDTH  id being committed or killed.
- commit_kill  in  1  kill flag for the committed id.
- result_valid / result_ready  out / in  1  result handshake.
- result_id  out  X_ID_WIDTH  id of the returned result.
- result_data  out  X_RFR_WIDTH  result value.
- result_rd  out  5  destination register.
- result_we  out  1  register write enable.
- result_exc, result_dbg, result_err  out  1 each  constant 0.
- result_exccode  out  6  constant 0.
- outstanding  out  $clog2(DEPTH)+1  number of live queue entries.

## Operation
- Decode:
  - Accept iff instr[6:0]==7'b0001011 and funct3 (instr[14:12]) < 4.
  - Ops: 0 ADD (rs1+rs2, modulo 2^X_RFR_WIDTH); 1 XOR; 2 MINU; 3 MAXU. MINU/MAXU compare unsigned. funct7 is ignored.
- Issue response (combinational from issue_instr):
  - issue_accept as above.
  - issue_writeback = accept && rd!=0.
  - issue_loadstore, issue_dualwrite, issue_dualread and issue_exc are always 0.
- issue_ready = (outstanding != DEPTH).
- On an issue handshake with accept=1, write one entry at the tail: {id, funct3, rd, ops=0, committed=0, killed=0}. A rejected instruction completes its handshake but allocates nothing.
- Register channel:
  - register_ready = &register_rs_valid.
  - On handshake, capture rs1/rs2 into the live entry with matching id and ops=0, then set ops=1.
  - If no live entry matches (late transfer for a killed or rejected id), the data is discarded.
- Commit channel: on commit_valid, match the live uncommitted entry with the same id; set committed=1 and killed=commit_kill. A commit that matches nothing is ignored.
- Head retire:
  - If head is committed and killed, dequeue silently in that cycle; no result is produced and ops is not required.
  - If head is committed, not killed and ops=1, drive result_valid=1.
  - Result fields: result_id = id, result_data = ALU(funct3, rs1, rs2), result_rd = rd, result_we = (rd!=0).
  - Dequeue on result_valid && result_ready.
- Ids of live entries are unique; the core guarantees this, and the block does not check it.
- Simultaneous events:
  - Issue enqueue and head dequeue in the same cycle leave outstanding unchanged.
  - Register capture and commit to the same entry in the same cycle both take effect.
  - When full, issue_ready=0 even if a dequeue occurs that cycle (no bypass).
- Pointers wrap modulo DEPTH.

## Timing
- Reset (resetb low, asynchronous):
  - Queue empty; all entry flags 0; outstanding=0.
  - result_valid=0; issue_ready=1; result_id, result_data, result_rd and result_we are 0.
- A reset mid-operation drops all entries immediately. No results are emitted afterwards.
- issue_ready, register_ready and the issue response are combinational. Entry state updates on the rising edge of the handshake cycle.
- Latency:
  - The last of {commit, register capture} in cycle N gives result_valid=1 in cycle N+1.
  - A kill in cycle N on the head entry dequeues it at edge N+1, so the next entry may present in N+1.
- While result_ready=0, result_valid and every result field hold stable.
- Results leave strictly in issue order. A committed younger entry waits behind an uncommitted head.

## Test plan
- Issue 0x0000028B (ADD, rd=5) with id=1 and ops rs1=0x0000_0003, rs2=0x0000_0004, then commit id=1 with kill=0:
  - issue_accept=1 and issue_writeback=1.
  - Next cycle result_valid=1 with result_data=0x7, result_rd=5, result_we=1.
- Issue 0x0000428B (funct3=4) with id=2:
  - issue_accept=0 and outstanding stays 0.
  - A following register transfer with id=2 is consumed with no effect.
- Issue ids 1..4 with no commits:
  - outstanding=4 and issue_ready=0.
  - Commit and drain id=1 (result_ready=1) → outstanding=3 and issue_ready=1 the next cycle.
- Issue id=3 (XOR) then id=4 (MAXU, rs1=0xFFFF_FFFF, rs2=1):
  - Commit id=4 first, then id=3 two cycles later.
  - The id=3 result (xor value) appears before the id=4 result (0xFFFF_FFFF).
- Issue id=6, then commit id=6 with kill=1 before any register transfer:
  - No result_valid.
  - outstanding returns to 0 one cycle later.
  - A late register transfer for id=6 is accepted and discarded.
- With 3 entries live and result_valid held, assert resetb=0 mid-cycle:
  - result_valid=0 and outstanding=0 immediately.
  - issue_ready=1.

Source files
------------

// File: rtl/xif_copro_ctrl_if.sv
// XIF channel bundle between the core (master) and the coprocessor
// controller (slave): issue, register, commit and result channels.
interface xif_copro_ctrl_if #(
  parameter int X_ID_WIDTH  = 4,
  parameter int X_RFR_WIDTH = 32
);
  // issue channel
  logic                     issue_valid;
  logic                     issue_ready;
  logic [31:0]              issue_instr;
  logic [X_ID_WIDTH-1:0]    issue_id;
  logic                     issue_accept;
  logic                     issue_writeback;
  logic                     issue_loadstore;
  logic                     issue_dualwrite;
  logic [2:0]               issue_dualread;
  logic                     issue_exc;
  // register channel
  logic                     register_valid;
  logic                     register_ready;
  logic [X_ID_WIDTH-1:0]    register_id;
  logic [2*X_RFR_WIDTH-1:0] register_rs;
  logic [1:0]               register_rs_valid;
  // commit channel
  logic                     commit_valid;
  logic [X_ID_WIDTH-1:0]    commit_id;
  logic                     commit_kill;
  // result channel
  logic                     result_valid;
  logic                     result_ready;
  logic [X_ID_WIDTH-1:0]    result_id;
  logic [X_RFR_WIDTH-1:0]   result_data;
  logic [4:0]               result_rd;
  logic                     result_we;
  logic                     result_exc;
  logic                     result_dbg;
  logic                     result_err;
  logic [5:0]               result_exccode;

  modport master (
    output issue_valid, issue_instr, issue_id,
    output register_valid, register_id, register_rs, register_rs_valid,
    output commit_valid, commit_id, commit_kill,
    output result_ready,
    input  issue_ready, issue_accept, issue_writeback, issue_loadstore,
    input  issue_dualwrite, issue_dualread, issue_exc,
    input  register_ready,
    input  result_valid, result_id, result_data, result_rd, result_we,
    input  result_exc, result_dbg, result_err, result_exccode
  );

  modport slave (
    input  issue_valid, issue_instr, issue_id,
    input  register_valid, register_id, register_rs, register_rs_valid,
    input  commit_valid, commit_id, commit_kill,
    input  result_ready,
    output issue_ready, issue_accept, issue_writeback, issue_loadstore,
    output issue_dualwrite, issue_dualread, issue_exc,
    output register_ready,
    output result_valid, result_id, result_data, result_rd, result_we,
    output result_exc, result_dbg, result_err, result_exccode
  );
endinterface

// File: rtl/xif_copro_ctrl.sv
// Coprocessor-side XIF controller: decodes custom-0 ALU ops, keeps accepted
// instructions in an in-order queue, collects operands and commit/kill
// status per entry, and returns results strictly in issue order.
module xif_copro_ctrl #(
  parameter int X_ID_WIDTH  = 4,
  parameter int X_RFR_WIDTH = 32,
  parameter int DEPTH       = 4
) (
  input  logic                   clk,
  input  logic                   resetb,
  xif_copro_ctrl_if.slave        xif,
  output logic [$clog2(DEPTH):0] outstanding
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // per-entry payload (no reset needed: only read while the entry is live)
  logic [X_ID_WIDTH-1:0]  id_reg  [DEPTH];
  logic [1:0]             op_reg  [DEPTH];
  logic [4:0]             rd_reg  [DEPTH];
  logic [X_RFR_WIDTH-1:0] rs1_reg [DEPTH];
  logic [X_RFR_WIDTH-1:0] rs2_reg [DEPTH];

  // per-entry status flags
  logic [DEPTH-1:0] ops_reg;
  logic [DEPTH-1:0] committed_reg;
  logic [DEPTH-1:0] killed_reg;

  logic [PTR_W-1:0] head_reg;
  logic [PTR_W-1:0] tail_reg;
  logic [CNT_W-1:0] count_reg;

  logic             accept;
  logic             reg_hs;
  logic             enq;
  logic             deq;
  logic             head_live;
  logic             head_drop;
  logic             res_valid;
  logic [DEPTH-1:0] live;
  logic [DEPTH-1:0] reg_match;
  logic [DEPTH-1:0] com_match;
  logic [X_RFR_WIDTH-1:0] alu_out;
  logic             unused_instr_bits;

  function automatic logic [X_RFR_WIDTH-1:0] alu(input logic [1:0] op,
                                                 input logic [X_RFR_WIDTH-1:0] a,
                                                 input logic [X_RFR_WIDTH-1:0] b);
    case (op)
      2'd0:    return a + b;
      2'd1:    return a ^ b;
      2'd2:    return (a < b) ? a : b;
      default: return (a > b) ? a : b;
    endcase
  endfunction

  // custom-0 opcode with funct3 in 0..3 (bit 14 clear); funct7 and rs fields unused
  assign accept            = (xif.issue_instr[6:0] == 7'b0001011) && !xif.issue_instr[14];
  assign unused_instr_bits = ^xif.issue_instr[31:15];

  assign xif.issue_ready     = (count_reg != CNT_W'(DEPTH));
  assign xif.issue_accept    = accept;
  assign xif.issue_writeback = accept && (xif.issue_instr[11:7] != 5'd0);
  assign xif.issue_loadstore = 1'b0;
  assign xif.issue_dualwrite = 1'b0;
  assign xif.issue_dualread  = 3'd0;
  assign xif.issue_exc       = 1'b0;
  assign xif.register_ready  = &xif.register_rs_valid;

  assign enq    = xif.issue_valid && xif.issue_ready && accept;
  assign reg_hs = xif.register_valid && xif.register_ready;

  // liveness is the entry's age relative to head; id matches only hit live entries
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [PTR_W-1:0] age;
    assign age           = PTR_W'(gi) - head_reg;
    assign live[gi]      = {1'b0, age} < count_reg;
    assign reg_match[gi] = reg_hs && live[gi] && !ops_reg[gi] &&
                           (id_reg[gi] == xif.register_id);
    assign com_match[gi] = xif.commit_valid && live[gi] && !committed_reg[gi] &&
                           (id_reg[gi] == xif.commit_id);
  end

  // a kill landing on the head this cycle drops it at this edge, not one later
  assign head_live = (count_reg != '0);
  assign head_drop = head_live &&
                     ((committed_reg[head_reg] && killed_reg[head_reg]) ||
                      (com_match[head_reg] && xif.commit_kill));
  assign res_valid = head_live && committed_reg[head_reg] &&
                     !killed_reg[head_reg] && ops_reg[head_reg];
  assign deq       = head_drop || (res_valid && xif.result_ready);
  assign alu_out   = alu(op_reg[head_reg], rs1_reg[head_reg], rs2_reg[head_reg]);

  // result fields are forced to zero when nothing is presented
  assign xif.result_valid   = res_valid;
  assign xif.result_id      = res_valid ? id_reg[head_reg] : '0;
  assign xif.result_data    = res_valid ? alu_out : '0;
  assign xif.result_rd      = res_valid ? rd_reg[head_reg] : 5'd0;
  assign xif.result_we      = res_valid && (rd_reg[head_reg] != 5'd0);
  assign xif.result_exc     = 1'b0;
  assign xif.result_dbg     = 1'b0;
  assign xif.result_err     = 1'b0;
  assign xif.result_exccode = 6'd0;
  assign outstanding        = count_reg;

  // queue pointers, occupancy and per-entry status flags
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      head_reg      <= '0;
      tail_reg      <= '0;
      count_reg     <= '0;
      ops_reg       <= '0;
      committed_reg <= '0;
      killed_reg    <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (enq && (tail_reg == PTR_W'(i))) begin
          ops_reg[i]       <= 1'b0;
          committed_reg[i] <= 1'b0;
          killed_reg[i]    <= 1'b0;
        end else begin
          if (reg_match[i]) begin
            ops_reg[i] <= 1'b1;
          end
          if (com_match[i]) begin
            committed_reg[i] <= 1'b1;
            killed_reg[i]    <= xif.commit_kill;
          end
        end
      end
      if (enq) begin
        tail_reg <= tail_reg + PTR_W'(1);
      end
      if (deq) begin
        head_reg <= head_reg + PTR_W'(1);
      end
      count_reg <= count_reg + CNT_W'(enq) - CNT_W'(deq);
    end
  end

  // entry payload: decode fields on enqueue, operands on register capture
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (enq && (tail_reg == PTR_W'(i))) begin
        id_reg[i] <= xif.issue_id;
        op_reg[i] <= xif.issue_instr[13:12];
        rd_reg[i] <= xif.issue_instr[11:7];
      end
      if (reg_match[i]) begin
        rs1_reg[i] <= xif.register_rs[X_RFR_WIDTH-1:0];
        rs2_reg[i] <= xif.register_rs[2*X_RFR_WIDTH-1:X_RFR_WIDTH];
      end
    end
  end
endmodule

// File: tb/tb_xif_copro_ctrl.sv
// Bench for xif_copro_ctrl: directed scenarios plus a randomized run checked
// against a queue-based reference model of the offload protocol.
module tb_xif_copro_ctrl;
  localparam int IDW   = 4;
  localparam int RW    = 32;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       resetb;
  logic [2:0] outstanding;
  int         total = 0;
  int         bad   = 0;

  xif_copro_ctrl_if #(.X_ID_WIDTH(IDW), .X_RFR_WIDTH(RW)) xif ();

  xif_copro_ctrl #(.X_ID_WIDTH(IDW), .X_RFR_WIDTH(RW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .resetb     (resetb),
    .xif        (xif),
    .outstanding(outstanding)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [1:0]     op;
    logic [4:0]     rd;
    logic [RW-1:0]  rs1;
    logic [RW-1:0]  rs2;
    logic           has_ops;
    logic           committed;
    logic           killed;
  } ent_t;

  ent_t q[$];

  function automatic logic [31:0] mk_instr(int op, int rd);
    return (32'(op) << 12) | (32'(rd) << 7) | 32'h0000_000B;
  endfunction

  function automatic logic m_accept(logic [31:0] ins);
    logic [6:0] opc;
    logic [2:0] f3;
    opc = ins[6:0];
    f3  = ins[14:12];
    return (opc == 7'h0B) && (f3 < 3'd4);
  endfunction

  function automatic logic [RW-1:0] m_alu(int op, logic [RW-1:0] a, logic [RW-1:0] b);
    if (op == 0) return a + b;
    if (op == 1) return a ^ b;
    if (op == 2) return (a < b) ? a : b;
    return (a > b) ? a : b;
  endfunction

  function automatic logic exp_valid();
    if (q.size() == 0) return 1'b0;
    return q[0].committed && !q[0].killed && q[0].has_ops;
  endfunction

  task automatic drive_idle();
    xif.issue_valid       = 1'b0;
    xif.issue_instr       = 32'd0;
    xif.issue_id          = '0;
    xif.register_valid    = 1'b0;
    xif.register_id       = '0;
    xif.register_rs       = '0;
    xif.register_rs_valid = 2'b00;
    xif.commit_valid      = 1'b0;
    xif.commit_id         = '0;
    xif.commit_kill       = 1'b0;
    xif.result_ready      = 1'b0;
  endtask

  // advance the model by one clock using the inputs currently driven, then clock
  task automatic tick();
    logic pop;
    logic issue_hs;
    ent_t e;
    if (!resetb) begin
      q.delete();
    end else begin
      pop      = 1'b0;
      issue_hs = xif.issue_valid && (q.size() < DEPTH) && m_accept(xif.issue_instr);
      if (q.size() != 0) begin
        if (q[0].committed && q[0].killed) pop = 1'b1;
        else if (xif.commit_valid && xif.commit_kill && !q[0].committed &&
                 q[0].id == xif.commit_id) pop = 1'b1;
        else if (exp_valid() && xif.result_ready) pop = 1'b1;
      end
      if (xif.register_valid && xif.register_rs_valid == 2'b11) begin
        for (int i = 0; i < q.size(); i++) begin
          if (!q[i].has_ops && q[i].id == xif.register_id) begin
            e = q[i];
            e.rs1 = xif.register_rs[RW-1:0];
            e.rs2 = xif.register_rs[2*RW-1:RW];
            e.has_ops = 1'b1;
            q[i] = e;
            break;
          end
        end
      end
      if (xif.commit_valid) begin
        for (int i = 0; i < q.size(); i++) begin
          if (!q[i].committed && q[i].id == xif.commit_id) begin
            e = q[i];
            e.committed = 1'b1;
            e.killed = xif.commit_kill;
            q[i] = e;
            break;
          end
        end
      end
      if (pop) void'(q.pop_front());
      if (issue_hs) begin
        e = '0;
        e.id = xif.issue_id;
        e.op = xif.issue_instr[13:12];
        e.rd = xif.issue_instr[11:7];
        q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_issue(int id, logic [31:0] ins);
    drive_idle();
    xif.issue_valid = 1'b1;
    xif.issue_id    = IDW'(id);
    xif.issue_instr = ins;
    tick();
  endtask

  task automatic test_reset();
    q.delete();
    drive_idle();
    resetb = 1'b0;
    #3;
    total++; if (xif.result_valid !== 1'b0) begin bad++; $display("FAIL reset_result_valid got=%0b want=0", xif.result_valid); end
    total++; if (xif.issue_ready !== 1'b1) begin bad++; $display("FAIL reset_issue_ready got=%0b want=1", xif.issue_ready); end
    total++; if (outstanding !== 3'd0) begin bad++; $display("FAIL reset_outstanding got=%0d want=0", outstanding); end
    total++; if ({xif.result_id, xif.result_data, xif.result_rd, xif.result_we} !== '0) begin
      bad++; $display("FAIL reset_result_fields got id=%0d data=%h rd=%0d we=%0b want all 0",
                      xif.result_id, xif.result_data, xif.result_rd, xif.result_we);
    end
    total++; if ({xif.result_exc, xif.result_dbg, xif.result_err, xif.result_exccode,
                  xif.issue_loadstore, xif.issue_dualwrite, xif.issue_dualread, xif.issue_exc} !== '0) begin
      bad++; $display("FAIL reset_const_zero got nonzero exc/dbg/err/exccode/loadstore/dual/exc");
    end
    @(posedge clk);
    #1;
    resetb = 1'b1;
    #1;
    total++; if (outstanding !== 3'd0) begin bad++; $display("FAIL reset_release_outstanding got=%0d want=0", outstanding); end
  endtask

  task automatic test_add();
    drive_idle();
    xif.issue_valid = 1'b1; xif.issue_id = 4'd1; xif.issue_instr = 32'h0000_028B;
    #1;
    total++; if (xif.issue_accept !== 1'b1) begin bad++; $display("FAIL add_accept got=%0b want=1", xif.issue_accept); end
    total++; if (xif.issue_writeback !== 1'b1) begin bad++; $display("FAIL add_writeback got=%0b want=1", xif.issue_writeback); end
    tick();
    drive_idle();
    xif.register_valid = 1'b1; xif.register_id = 4'd1;
    xif.register_rs = {32'h0000_0004, 32'h0000_0003}; xif.register_rs_valid = 2'b11;
    #1;
    total++; if (xif.register_ready !== 1'b1) begin bad++; $display("FAIL add_register_ready got=%0b want=1", xif.register_ready); end
    tick();
    drive_idle();
    xif.commit_valid = 1'b1; xif.commit_id = 4'd1;
    #1;
    total++; if (xif.result_valid !== 1'b0) begin bad++; $display("FAIL add_early_valid got=%0b want=0", xif.result_valid); end
    tick();
    drive_idle();
    for (int hold = 0; hold < 2; hold++) begin
      #1;
      total++; if (xif.result_valid !== 1'b1 || xif.result_data !== 32'h7 || xif.result_rd !== 5'd5 ||
                   xif.result_we !== 1'b1 || xif.result_id !== 4'd1) begin
        bad++; $display("FAIL add_result[%0d] got v=%0b id=%0d data=%h rd=%0d we=%0b want v=1 id=1 data=7 rd=5 we=1",
                        hold, xif.result_valid, xif.result_id, xif.result_data, xif.result_rd, xif.result_we);
      end
      if (hold == 0) tick();
    end
    xif.result_ready = 1'b1;
    tick();
    drive_idle();
    #1;
    total++; if (xif.result_valid !== 1'b0 || outstanding !== 3'd0) begin
      bad++; $display("FAIL add_drain got v=%0b out=%0d want v=0 out=0", xif.result_valid, outstanding);
    end
  endtask

  task automatic test_reject();
    drive_idle();
    xif.issue_valid = 1'b1; xif.issue_id = 4'd2; xif.issue_instr = 32'h0000_428B;
    #1;
    total++; if (xif.issue_accept !== 1'b0 || xif.issue_writeback !== 1'b0) begin
      bad++; $display("FAIL reject_response got acc=%0b wb=%0b want 0 0", xif.issue_accept, xif.issue_writeback);
    end
    tick();
    drive_idle();
    xif.register_valid = 1'b1; xif.register_id = 4'd2;
    xif.register_rs = {32'h1, 32'h2}; xif.register_rs_valid = 2'b11;
    #1;
    total++; if (outstanding !== 3'd0 || xif.register_ready !== 1'b1) begin
      bad++; $display("FAIL reject_outstanding got out=%0d rready=%0b want out=0 rready=1", outstanding, xif.register_ready);
    end
    tick();
    drive_idle();
    #1;
    total++; if (outstanding !== 3'd0 || xif.result_valid !== 1'b0) begin
      bad++; $display("FAIL reject_late_reg got out=%0d v=%0b want 0 0", outstanding, xif.result_valid);
    end
  endtask

  task automatic test_full();
    for (int k = 1; k <= 4; k++) do_issue(k, mk_instr(0, k));
    drive_idle();
    xif.register_valid = 1'b1; xif.register_id = 4'd1;
    xif.register_rs = {32'd20, 32'd10}; xif.register_rs_valid = 2'b11;
    xif.commit_valid = 1'b1; xif.commit_id = 4'd1;
    xif.issue_valid = 1'b1; xif.issue_id = 4'd9; xif.issue_instr = mk_instr(0, 9);
    #1;
    total++; if (outstanding !== 3'd4 || xif.issue_ready !== 1'b0) begin
      bad++; $display("FAIL full_state got out=%0d iready=%0b want out=4 iready=0", outstanding, xif.issue_ready);
    end
    tick();
    drive_idle();
    xif.result_ready = 1'b1;
    xif.issue_valid = 1'b1; xif.issue_id = 4'd9; xif.issue_instr = mk_instr(0, 9);
    #1;
    total++; if (xif.result_valid !== 1'b1 || xif.result_data !== 32'd30 || xif.issue_ready !== 1'b0) begin
      bad++; $display("FAIL full_dequeue got v=%0b data=%h iready=%0b want v=1 data=1e iready=0",
                      xif.result_valid, xif.result_data, xif.issue_ready);
    end
    tick();
    drive_idle();
    #1;
    total++; if (outstanding !== 3'd3 || xif.issue_ready !== 1'b1) begin
      bad++; $display("FAIL full_after_drain got out=%0d iready=%0b want out=3 iready=1", outstanding, xif.issue_ready);
    end
    for (int k = 2; k <= 4; k++) begin
      drive_idle();
      xif.commit_valid = 1'b1; xif.commit_id = IDW'(k); xif.commit_kill = 1'b1;
      tick();
    end
    drive_idle();
    #1;
    total++; if (outstanding !== 3'd0 || xif.result_valid !== 1'b0) begin
      bad++; $display("FAIL full_kill_cleanup got out=%0d v=%0b want 0 0", outstanding, xif.result_valid);
    end
  endtask

  task automatic test_order();
    logic [31:0] a;
    logic [31:0] b;
    a = $urandom();
    b = $urandom();
    do_issue(3, mk_instr(1, 7));
    do_issue(4, mk_instr(3, 8));
    drive_idle();
    xif.register_valid = 1'b1; xif.register_id = 4'd3; xif.register_rs = {b, a}; xif.register_rs_valid = 2'b11;
    tick();
    drive_idle();
    xif.register_valid = 1'b1; xif.register_id = 4'd4;
    xif.register_rs = {32'h0000_0001, 32'hFFFF_FFFF}; xif.register_rs_valid = 2'b11;
    tick();
    drive_idle();
    xif.commit_valid = 1'b1; xif.commit_id = 4'd4;
    tick();
    drive_idle();
    xif.result_ready = 1'b1;
    #1;
    total++; if (xif.result_valid !== 1'b0) begin bad++; $display("FAIL order_younger_waits got v=%0b want=0", xif.result_valid); end
    tick();
    drive_idle();
    xif.commit_valid = 1'b1; xif.commit_id = 4'd3;
    tick();
    drive_idle();
    xif.result_ready = 1'b1;
    #1;
    total++; if (xif.result_valid !== 1'b1 || xif.result_id !== 4'd3 || xif.result_data !== (a ^ b) || xif.result_rd !== 5'd7) begin
      bad++; $display("FAIL order_first got v=%0b id=%0d data=%h rd=%0d want v=1 id=3 data=%h rd=7",
                      xif.result_valid, xif.result_id, xif.result_data, xif.result_rd, a ^ b);
    end
    tick();
    #1;
    total++; if (xif.result_valid !== 1'b1 || xif.result_id !== 4'd4 || xif.result_data !== 32'hFFFF_FFFF) begin
      bad++; $display("FAIL order_second got v=%0b id=%0d data=%h want v=1 id=4 data=ffffffff",
                      xif.result_valid, xif.result_id, xif.result_data);
    end
    tick();
    drive_idle();
    #1;
    total++; if (outstanding !== 3'd0) begin bad++; $display("FAIL order_drain got out=%0d want=0", outstanding); end
  endtask

  task automatic test_kill();
    do_issue(6, mk_instr(0, 3));
    drive_idle();
    xif.commit_valid = 1'b1; xif.commit_id = 4'd6; xif.commit_kill = 1'b1;
    #1;
    total++; if (outstanding !== 3'd1 || xif.result_valid !== 1'b0) begin
      bad++; $display("FAIL kill_before got out=%0d v=%0b want out=1 v=0", outstanding, xif.result_valid);
    end
    tick();
    drive_idle();
    xif.register_valid = 1'b1; xif.register_id = 4'd6;
    xif.register_rs = {32'h5, 32'h6}; xif.register_rs_valid = 2'b11;
    #1;
    total++; if (outstanding !== 3'd0 || xif.result_valid !== 1'b0 || xif.register_ready !== 1'b1) begin
      bad++; $display("FAIL kill_after got out=%0d v=%0b rready=%0b want out=0 v=0 rready=1",
                      outstanding, xif.result_valid, xif.register_ready);
    end
    tick();
    drive_idle();
    #1;
    total++; if (outstanding !== 3'd0 || xif.result_valid !== 1'b0) begin
      bad++; $display("FAIL kill_late_reg got out=%0d v=%0b want 0 0", outstanding, xif.result_valid);
    end
  endtask

  task automatic test_random();
    int          k;
    int          nid;
    logic        taken;
    logic [31:0] r;
    logic [2:0]  f3;
    logic [6:0]  opc;
    logic [4:0]  rd;
    for (int cyc = 0; cyc < 400; cyc++) begin
      drive_idle();
      xif.result_ready      = ($urandom_range(0, 3) != 0);
      xif.register_rs_valid = 2'($urandom_range(0, 3));
      r   = $urandom();
      f3  = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      opc = ($urandom_range(0, 9) == 0) ? 7'h33 : 7'h0B;
      rd  = 5'($urandom_range(0, 31));
      xif.issue_instr = {r[31:15], f3, rd, opc};
      if ($urandom_range(0, 2) == 0) begin
        nid = 0;
        for (int t = 0; t < 64; t++) begin
          nid   = $urandom_range(0, 15);
          taken = 1'b0;
          foreach (q[j]) if (q[j].id == IDW'(nid)) taken = 1'b1;
          if (!taken) break;
        end
        xif.issue_valid = 1'b1;
        xif.issue_id    = IDW'(nid);
      end
      if (q.size() != 0 && $urandom_range(0, 1) == 0) begin
        k = $urandom_range(0, q.size() - 1);
        xif.register_valid    = 1'b1;
        xif.register_id       = q[k].id;
        xif.register_rs       = {$urandom(), $urandom()};
        xif.register_rs_valid = ($urandom_range(0, 4) == 0) ? 2'b01 : 2'b11;
      end
      if (q.size() != 0 && $urandom_range(0, 2) == 0) begin
        k = $urandom_range(0, q.size() - 1);
        xif.commit_valid = 1'b1;
        xif.commit_id    = q[k].id;
        xif.commit_kill  = ($urandom_range(0, 3) == 0);
      end
      #1;
      total++; if (xif.issue_ready !== (q.size() < DEPTH) || outstanding !== 3'(q.size())) begin
        bad++; $display("FAIL rand_occupancy cyc=%0d got out=%0d iready=%0b want out=%0d", cyc, outstanding, xif.issue_ready, q.size());
      end
      total++; if (xif.issue_accept !== m_accept(xif.issue_instr) ||
                   xif.issue_writeback !== (m_accept(xif.issue_instr) && rd != 5'd0) ||
                   xif.register_ready !== (xif.register_rs_valid == 2'b11)) begin
        bad++; $display("FAIL rand_comb cyc=%0d got acc=%0b wb=%0b rready=%0b", cyc,
                        xif.issue_accept, xif.issue_writeback, xif.register_ready);
      end
      total++; if (xif.result_valid !== exp_valid()) begin
        bad++; $display("FAIL rand_valid cyc=%0d got=%0b want=%0b", cyc, xif.result_valid, exp_valid());
      end
      if (exp_valid()) begin
        total++; if (xif.result_id !== q[0].id || xif.result_data !== m_alu(int'(q[0].op), q[0].rs1, q[0].rs2) ||
                     xif.result_rd !== q[0].rd || xif.result_we !== (q[0].rd != 5'd0)) begin
          bad++; $display("FAIL rand_result cyc=%0d got id=%0d data=%h rd=%0d we=%0b want id=%0d data=%h rd=%0d",
                          cyc, xif.result_id, xif.result_data, xif.result_rd, xif.result_we,
                          q[0].id, m_alu(int'(q[0].op), q[0].rs1, q[0].rs2), q[0].rd);
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    drive_idle();
    resetb = 1'b0;
    tick();
    resetb = 1'b1;
    for (int k = 10; k <= 12; k++) do_issue(k, mk_instr(0, 1));
    drive_idle();
    xif.register_valid = 1'b1; xif.register_id = 4'd10;
    xif.register_rs = {32'h2, 32'h1}; xif.register_rs_valid = 2'b11;
    xif.commit_valid = 1'b1; xif.commit_id = 4'd10;
    tick();
    drive_idle();
    #1;
    total++; if (xif.result_valid !== 1'b1 || outstanding !== 3'd3) begin
      bad++; $display("FAIL mid_before got v=%0b out=%0d want v=1 out=3", xif.result_valid, outstanding);
    end
    #2;
    resetb = 1'b0;
    q.delete();
    #1;
    total++; if (xif.result_valid !== 1'b0 || outstanding !== 3'd0 || xif.issue_ready !== 1'b1 || xif.result_data !== 32'd0) begin
      bad++; $display("FAIL mid_reset got v=%0b out=%0d iready=%0b data=%h want v=0 out=0 iready=1 data=0",
                      xif.result_valid, outstanding, xif.issue_ready, xif.result_data);
    end
    tick();
    resetb = 1'b1;
    xif.result_ready = 1'b1;
    tick();
    #1;
    total++; if (xif.result_valid !== 1'b0 || outstanding !== 3'd0) begin
      bad++; $display("FAIL mid_after got v=%0b out=%0d want 0 0", xif.result_valid, outstanding);
    end
  endtask

  initial begin
    resetb = 1'b0;
    drive_idle();
    test_reset();
    test_add();
    test_reject();
    test_full();
    test_order();
    test_kill();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
